// File: rtl/alu_defs_pkg.sv
// rtl/alu_defs_pkg.sv - shared opcode, cond, flag and field definitions for the ALU issue path
package alu_defs_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_AND    = 4'd4;
  localparam logic [3:0] OP_XOR    = 4'd5;
  localparam logic [3:0] OP_MOVN   = 4'd6;
  localparam logic [3:0] OP_MOVREG = 4'd7;
  localparam logic [3:0] OP_CMP    = 4'd8;
  localparam logic [3:0] OP_LDR    = 4'd9;
  localparam logic [3:0] OP_STR    = 4'd10;
  localparam logic [3:0] OP_NOP    = 4'd15;

  localparam logic [3:0] COND_EQ = 4'd1;
  localparam logic [3:0] COND_GT = 4'd2;
  localparam logic [3:0] COND_LT = 4'd3;
  localparam logic [3:0] COND_GE = 4'd4;
  localparam logic [3:0] COND_LE = 4'd5;
  localparam logic [3:0] COND_HI = 4'd6;
  localparam logic [3:0] COND_LO = 4'd7;
  localparam logic [3:0] COND_HS = 4'd8;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // LSB positions of the instruction fields; rn/rm are relative to imvalue,
  // which itself starts at bit 0 so they also index the full word.
  localparam int F_COND   = 28;
  localparam int F_OPCODE = 24;
  localparam int F_SBIT   = 23;
  localparam int F_SRC    = 20;
  localparam int F_RD     = 16;
  localparam int F_IMM    = 0;
  localparam int F_RN     = 12;
  localparam int F_RM     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_MOVREG;
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'd11) && (op <= 4'd14);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - evaluates an instruction cond code against the NZCV flags
module cond_eval
  import alu_defs_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       met
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    met = 1'b1;
    case (cond)
      COND_EQ: met = z;
      COND_GT: met = !z && (n == v);
      COND_LT: met = !z && (n != v);
      COND_GE: met = (n == v);
      COND_LE: met = (n != v);
      COND_HI: met = !z && c;
      COND_LO: met = !c;
      COND_HS: met = c;
      default: met = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - serialised instruction issue, register file, writeback and LDR/STR sequencing
module alu_issue_ctrl
  import alu_defs_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic              alu_sbit,
  output logic [3:0]        alu_cond,
  output logic [3:0]        alu_opcode,
  output logic [2:0]        alu_srcontrol,
  output logic [15:0]       alu_imvalue,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [3:0]        flags,
  output logic              retire,
  output logic              err,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t            state;
  logic [DATA_W-1:0] regs [16];
  logic [3:0]        rd_q;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] load_q;
  logic [3:0]        rflags_q;
  logic              met_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              cond_met;
  logic [3:0]        rn;

  // The latched ALU fields double as the instruction register.
  assign rn = alu_imvalue[F_RN +: 4];

  cond_eval u_cond_eval (
    .cond  (alu_cond),
    .flags (flags),
    .met   (cond_met)
  );

  assign dbg_data = regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      instr_ready   <= 1'b1;
      alu_in1       <= '0;
      alu_in2       <= '0;
      alu_sbit      <= 1'b0;
      alu_cond      <= '0;
      alu_opcode    <= '0;
      alu_srcontrol <= '0;
      alu_imvalue   <= '0;
      rd_q          <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      flags         <= '0;
      retire        <= 1'b0;
      err           <= 1'b0;
      res_q         <= '0;
      load_q        <= '0;
      rflags_q      <= '0;
      met_q         <= 1'b0;
      timeout_q     <= 1'b0;
      tmo_cnt       <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      retire <= 1'b0;
      err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            alu_cond      <= instr[F_COND +: 4];
            alu_opcode    <= instr[F_OPCODE +: 4];
            alu_sbit      <= instr[F_SBIT];
            alu_srcontrol <= instr[F_SRC +: 3];
            alu_imvalue   <= instr[F_IMM +: 16];
            rd_q          <= instr[F_RD +: 4];
            alu_in1       <= regs[instr[F_RN +: 4]];
            alu_in2       <= regs[instr[F_RM +: 4]];
            instr_ready   <= 1'b0;
            state         <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          res_q     <= alu_result;
          rflags_q  <= alu_flags;
          met_q     <= cond_met;
          timeout_q <= 1'b0;
          if (cond_met && (alu_opcode == OP_LDR || alu_opcode == OP_STR)) begin
            mem_req   <= 1'b1;
            mem_we    <= (alu_opcode == OP_STR);
            mem_addr  <= regs[rn];
            mem_wdata <= regs[rd_q];
            tmo_cnt   <= '0;
            state     <= ST_MEM;
          end else begin
            retire <= 1'b1;
            err    <= is_illegal(alu_opcode);
            state  <= ST_WB;
          end
        end

        ST_MEM: begin
          if (mem_ack) begin
            load_q  <= mem_rdata;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            retire  <= 1'b1;
            state   <= ST_WB;
          end else if (tmo_cnt == CNT_LAST) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            timeout_q <= 1'b1;
            retire    <= 1'b1;
            err       <= 1'b1;
            state     <= ST_WB;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_WB: begin
          // Illegal opcodes are neither ALU ops nor LDR/CMP, so they fall through with no writes.
          if (met_q && !timeout_q) begin
            if (is_alu_op(alu_opcode)) regs[rd_q] <= res_q;
            else if (alu_opcode == OP_LDR) regs[rd_q] <= load_q;
          end
          if (met_q && ((alu_sbit && is_alu_op(alu_opcode)) || alu_opcode == OP_CMP))
            flags <= rflags_q;
          instr_ready <= 1'b1;
          state       <= ST_IDLE;
        end

        default: begin
          instr_ready <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Instruction-side counterpart of the ALU: accepts 32-bit instruction words over a valid/ready handshake and decodes them into the ALU's input fields.
- Reads operands from an internal 16x32 register file and drives the combinational ALU (external instance).
- Captures the ALU result and flags, performs conditional writeback and the NZCV flags register, and sequences LDR/STR through a memory request/acknowledge handshake.

Parameters:
- MEM_TIMEOUT, 16, cycles allowed for mem_ack before the access is aborted.
- DATA_W, 32, datapath width; fixed at 32 for this processor.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction word available
- instr  in  32  instruction word
- instr_ready  out  1  unit can accept an instruction
- alu_in1, alu_in2  out  32  operands to ALU
- alu_sbit  out  1  ALU sbit
- alu_cond, alu_opcode  out  4  ALU cond and opcode
- alu_srcontrol  out  3  ALU shift/rotate control
- alu_imvalue  out  16  ALU immediate
- alu_result  in  32  ALU result
- alu_flags  in  4  ALU flags {N,Z,C,V}
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- mem_addr, mem_wdata  out  32  address and store data
- mem_rdata  in  32  load data
- mem_ack  in  1  memory completion
- flags  out  4  architectural NZCV register
- retire  out  1  one-cycle pulse per completed instruction
- err  out  1  one-cycle pulse: illegal opcode or memory timeout
- dbg_addr  in  4  register-file debug read address
- dbg_data  out  32  combinational R[dbg_addr]

Behaviour:
- Instruction encoding:
  - [31:28] cond, [27:24] opcode, [23] sbit, [22:20] srcontrol, [19:16] rd, [15:0] imvalue.
  - In register form, imvalue subfields are [15:12] rn, [11:8] rm, [7:3] shift amount, [2:0] reserved (ignored).
- Operand mapping: alu_in1 = R[rn], alu_in2 = R[rm], all other ALU fields taken straight from the latched instruction.
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 OR, 4 AND, 5 XOR, 6 MOVN, 7 MOVREG, 8 CMP, 9 LDR, 10 STR, 15 NOP. Opcodes 11-14 are illegal.
- Cond codes (evaluated against flags register):
  - 1 EQ: Z
  - 2 GT: !Z & N==V
  - 3 LT: !Z & N!=V
  - 4 GE: N==V
  - 5 LE: N!=V
  - 6 HI: !Z & C
  - 7 LO: !C
  - 8 HS: C
  - all others: always.
- FSM states: IDLE, EXEC, MEM, WB.
  - IDLE: instr_ready=1. On instr_valid & instr_ready, latch instr and go to EXEC.
  - EXEC: one cycle; ALU outputs driven from latched registers.
    - At end of EXEC, capture alu_result/alu_flags and evaluate cond against flags.
    - If cond met and opcode is LDR/STR, go to MEM; otherwise go to WB.
  - MEM: mem_req=1, mem_addr=R[rn], mem_we=(STR), mem_wdata=R[rd].
    - On mem_ack: LDR captures mem_rdata, then go to WB.
    - Timeout counter starts at 0 on MEM entry. If MEM_TIMEOUT cycles elapse without ack, drop mem_req, pulse err in WB, and perform no write.
  - WB: retire=1 for one cycle, then go to IDLE.
    - Register write: if cond met, write R[rd] for opcodes 0-7 (captured alu_result) and LDR (mem_rdata).
    - Flags update: flags <= captured alu_flags if cond met and (sbit & opcode 0-7, or opcode CMP).
    - CMP never writes a register.
    - Illegal opcode: no writes, err=1 alongside retire.
- Latency: non-memory instruction accepted at edge n, retire high in cycle n+2, next accept at edge n+3. Memory instruction: n+2+ack latency.
- Cond-failed instructions retire with no register, flag or memory side effects, and do not enter MEM.
- mem_req is held stable until ack; mem_ack outside MEM is ignored.
- Writes to rd take effect at the end of WB and are visible to the next instruction. No bypass is needed because issue is serialised.
- Reset values:
  - state IDLE; all 16 registers 0; flags 0000.
  - mem_req, mem_we, retire, err all 0; ALU output fields 0.
  - Reset mid-MEM drops mem_req on the same edge and discards the instruction.

Decomposition:
- Shared package alu_defs_pkg:
  - opcode constants (OP_ADD..OP_NOP), cond constants, flag bit indices N=3, Z=2, C=1, V=0.
  - instruction field bit positions and the FSM state enum.
- One sub-module, cond_eval: combinational cond plus flags in, met out. It is reused by the later pipeline.
- The register file stays inline.

Test Plan:
- ADD rd=1,rn=0,rm=0 with ALU model, then MOVN rd=2 imm=0x1234 -> R2=0x00001234, retire at accept+2, dbg_data(2)=0x1234.
- SUB with sbit=1, R3=5, R4=5 -> flags=0100. Then EQ-conditioned MOVN rd=5 imm=7 -> R5=7. Then NE-style GT-conditioned MOVN rd=6 -> R6 unchanged, retire still pulses.
- STR rn=1 (R1=0x40), rd=2 (R2=0x1234), ack after 3 cycles -> mem_req held 3 cycles, mem_we=1, mem_addr=0x40, mem_wdata=0x1234. Then LDR rd=7, rdata=0xDEADBEEF -> R7=0xDEADBEEF.
- LDR with mem_ack never asserted -> mem_req drops after 16 cycles, err and retire pulse together, rd unchanged.
- Opcode 12 -> err=1 with retire, no register or flag change. Back-to-back instr_valid -> instr_ready low in EXEC/MEM/WB, and the second word is accepted only in IDLE.
- Assert reset during MEM -> next cycle mem_req=0, state IDLE, flags=0000, all registers 0.
